// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register of the 5-stage core.
//
// Holds the PC and fetches one instruction word per request over a
// req/gnt/rvalid handshake, with at most one request outstanding. The
// registered instruction and its decoded fields go to decode/control.
// Decode stall holds IF/ID. An EX/MEM redirect flushes IF/ID and restarts
// fetching from the new PC.
//
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetch_cnt and
// perf_stall_cnt outputs.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address (= pc)
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata read data return, at least one cycle after gnt
//   id_stall          decode cannot accept; IF/ID holds
//   redirect_valid/pc taken jump/branch; flush and refetch from redirect_pc
//   if_valid/pc/instruction  IF/ID contents (NOP_INSN when invalid)
//   opcode..rd        field slices of if_instruction
//   perf_fetch_cnt    (FETCH_PERF_CNT_EN) instructions loaded into IF/ID
//   perf_stall_cnt    (FETCH_PERF_CNT_EN) cycles with id_stall && if_valid
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // One IF/ID entry; also the shape of the hold buffer.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
    } ifid_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;   // address of the outstanding request
    logic        drop_q, drop_d;       // next response belongs to a flushed path
    ifid_t       hold_q, hold_d;
    ifid_t       ifid_q, ifid_d;
    logic        load_word;            // load IF/ID straight from imem_rdata
    logic        load_buf;             // load IF/ID from the hold buffer

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        hold_d    = hold_q;
        ifid_d    = ifid_q;
        load_word = 1'b0;
        load_buf  = 1'b0;
        imem_req  = (state_q == S_REQ);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;   // wraps modulo 2^32
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!id_stall || !ifid_q.valid) begin
                        load_word = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        hold_d.valid = 1'b1;
                        hold_d.pc    = req_pc_q;
                        hold_d.insn  = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall || !hold_q.valid) begin
                    load_buf     = hold_q.valid;
                    hold_d.valid = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // IF/ID: new data, else bubble when decode is free, else hold.
        if (load_word) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = req_pc_q;
            ifid_d.insn  = imem_rdata;
        end else if (load_buf) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = hold_q.pc;
            ifid_d.insn  = hold_q.insn;
        end else if (!id_stall) begin
            ifid_d.valid = 1'b0;
            ifid_d.insn  = NOP_INSN;
        end

        // Redirect overrides everything above, including a stall.
        if (redirect_valid) begin
            pc_d         = redirect_pc & ~32'h3;
            ifid_d.valid = 1'b0;
            ifid_d.insn  = NOP_INSN;
            hold_d.valid = 1'b0;
            case (state_q)
                S_WAIT: begin
                    // A response arriving this very cycle is the stale one:
                    // discard it now. Otherwise mark the next one for dropping.
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        // Granted request is for the old path; its data is dropped.
                        state_d  = S_WAIT;
                        drop_d   = 1'b1;
                        req_pc_d = pc_q;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            hold_q   <= '{valid: 1'b0, pc: 32'h0, insn: NOP_INSN};
            ifid_q   <= '{valid: 1'b0, pc: 32'h0, insn: NOP_INSN};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
            ifid_q   <= ifid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_valid       = ifid_q.valid;
    assign if_pc          = ifid_q.pc;
    assign if_instruction = ifid_q.insn;

    assign opcode = ifid_q.insn[6:0];
    assign rd     = ifid_q.insn[11:7];
    assign funct3 = ifid_q.insn[14:12];
    assign rs1    = ifid_q.insn[19:15];
    assign rs2    = ifid_q.insn[24:20];
    assign funct7 = ifid_q.insn[31:25];

`ifdef FETCH_PERF_CNT_EN
    // Counters survive redirects; only reset clears them.
    logic fetch_load;
    assign fetch_load = (load_word || load_buf) && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_load)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (id_stall && ifid_q.valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, cycle-exact bench for fetch_stage. Instruction memory grants
// combinationally and returns word(addr) lat+1 cycles after the grant.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[19:0], 12'h0B3};
    endfunction

    int unsigned lat = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    int unsigned wcnt = 0;

    assign imem_gnt = imem_req;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (pend) begin
            if (wcnt == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(paddr);
                pend        <= 1'b0;
            end else begin
                wcnt <= wcnt - 1;
            end
        end
        if (imem_req && imem_gnt) begin
            if (lat == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(imem_addr);
            end else begin
                pend  <= 1'b1;
                paddr <= imem_addr;
                wcnt  <= lat - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] insn);
        chk({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, v});
        chk({tag, " if_pc"}, if_pc, pc);
        chk({tag, " if_instruction"}, if_instruction, insn);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({tag, " imem_addr"}, imem_addr, a);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick(); tick();

        // Reset state
        chk_if("rst", 1'b0, 32'h0, NOP);
        chk_req("rst", 1'b0, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst opcode", {25'b0, opcode}, 32'h13);
        rst_n = 1'b1;

        // 1: first fetch
        tick();                                   // IDLE -> REQ
        chk_req("t1 req", 1'b1, 32'h0);
        tick();                                   // gnt -> WAIT
        chk_req("t1 wait", 1'b0, 32'h0);
        tick();                                   // rvalid -> IF/ID
        chk_if("t1", 1'b1, 32'h0, 32'h0050_0093);
        chk("t1 opcode", {25'b0, opcode}, 32'h13);
        chk("t1 rd", {27'b0, rd}, 32'd1);
        chk("t1 funct7", {25'b0, funct7}, 32'h0);
        chk("t1 rs2", {27'b0, rs2}, 32'd5);
        chk("t1 rs1", {27'b0, rs1}, 32'd0);
        chk("t1 funct3", {29'b0, funct3}, 32'd0);
        chk_req("t1 next", 1'b1, 32'h4);

        // 2: streaming, bubble between words
        tick();
        chk_if("t2 bubble", 1'b0, 32'h0, NOP);
        tick();
        chk_if("t2 w4", 1'b1, 32'h4, 32'h0000_40B3);
        chk_req("t2 next", 1'b1, 32'h8);

        // 3: stall 5 cycles while 0x8 returns
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_if("t3 frozen", 1'b1, 32'h4, 32'h0000_40B3);
            chk_req("t3 noreq", 1'b0, 32'h0);
        end
        id_stall = 1'b0;
        tick();                                   // hold buffer -> IF/ID
        chk_if("t3 release", 1'b1, 32'h8, 32'h0000_80B3);
        chk_req("t3 next", 1'b1, 32'hC);
        tick(); tick();
        chk_if("t2 wC", 1'b1, 32'hC, 32'h0000_C0B3);
        chk_req("t2 next10", 1'b1, 32'h10);

        // 4: redirect during WAIT, response still outstanding
        lat = 1;
        tick();                                   // gnt 0x10
        chk_req("t4 wait", 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        chk_if("t4 flush", 1'b0, 32'hC, NOP);
        chk_req("t4 still wait", 1'b0, 32'h0);
        tick();                                   // stale word dropped
        chk("t4 dropped valid", {31'b0, if_valid}, 32'h0);
        chk_req("t4 refetch", 1'b1, 32'h100);
        lat = 0;
        tick(); tick();
        chk_if("t4 w100", 1'b1, 32'h100, 32'h0010_00B3);
        chk_req("t4 next", 1'b1, 32'h104);

        // 5: redirect + stall + rvalid in one cycle
        id_stall = 1'b1;
        tick();                                   // gnt 0x104, IF/ID held
        chk("t5 held valid", {31'b0, if_valid}, 32'h1);
        chk("t5 held pc", if_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        chk("t5 flush valid", {31'b0, if_valid}, 32'h0);
        chk("t5 flush insn", if_instruction, NOP);
        chk_req("t5 refetch", 1'b1, 32'h200);
        tick(); tick();
        chk_if("t5 w200", 1'b1, 32'h200, 32'h0020_00B3);
        chk_req("t5 next", 1'b1, 32'h204);

        // 6: redirect with gnt in REQ, then pc wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk_req("t6 wait", 1'b0, 32'h0);
        chk("t6 flush valid", {31'b0, if_valid}, 32'h0);
        tick();                                   // word for 0x204 dropped
        chk("t6 dropped valid", {31'b0, if_valid}, 32'h0);
        chk_req("t6 req top", 1'b1, 32'hFFFF_FFFC);
        tick();                                   // gnt, pc wraps
        chk("t6 pc wrap", imem_addr, 32'h0);
        tick();
        chk_if("t6 wtop", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_C0B3);
        chk("t6 opcode", {25'b0, opcode}, 32'h33);
        chk("t6 rd", {27'b0, rd}, 32'd1);
        chk("t6 funct3", {29'b0, funct3}, 32'd4);
        chk("t6 rs1", {27'b0, rs1}, 32'd31);
        chk("t6 rs2", {27'b0, rs2}, 32'd31);
        chk("t6 funct7", {25'b0, funct7}, 32'h7F);
        chk_req("t6 next", 1'b1, 32'h0);

        // Reset asserted mid-WAIT with a response still in flight
        id_stall = 1'b1;
        lat = 1;
        tick();                                   // gnt 0x0
        chk("t6 pre-rst valid", {31'b0, if_valid}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetch", perf_fetch_cnt, 32'd7);
        chk("perf stall", perf_stall_cnt, 32'd8);
`endif
        rst_n = 1'b0;
        #1;
        chk_if("t6 async rst", 1'b0, 32'h0, NOP);
        chk_req("t6 async rst", 1'b0, 32'h0);
        chk("t6 rst pc", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetch rst", perf_fetch_cnt, 32'd0);
        chk("perf stall rst", perf_stall_cnt, 32'd0);
`endif
        id_stall = 1'b0;
        tick();                                   // response fires during reset
        rst_n = 1'b1;
        lat = 0;
        tick();                                   // IDLE ignores rvalid
        chk_if("t6 post-rst", 1'b0, 32'h0, NOP);
        chk_req("t6 post-rst", 1'b1, 32'h0);
        tick(); tick();
        chk_if("t6 refetch0", 1'b1, 32'h0, 32'h0050_0093);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
